// File: rtl/fp_pipe_result_buffer.sv
// fp_pipe_result_buffer
//
// Credit-gated receive buffer for a fixed-latency floating-point pipeline that
// has no backpressure. Upstream issue is allowed only while
// inflight + count < DEPTH. Every issued argument set therefore has a FIFO slot
// reserved for its result. Results are stored opaquely and presented
// downstream on a valid/ready interface.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   src_vld/src_rdy upstream argument handshake (src_rdy = credit available)
//   arg_vld         pipeline issue strobe (src_vld & src_rdy)
//   res_vld/res     pipeline result stream, no backpressure
//   out_vld/out_rdy downstream handshake; out_data is the FIFO head, 0 when empty
//   inflight        issued sets whose result has not yet arrived
//   count           occupied FIFO entries
//   err_unexp       sticky: result arrived with nothing in flight
//   err_ovf         sticky: result arrived with FIFO full
module fp_pipe_result_buffer #(
  parameter int unsigned FLEN  = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_vld,
  output logic                       src_rdy,
  output logic                       arg_vld,
  input  logic                       res_vld,
  input  logic [FLEN-1:0]            res,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [FLEN-1:0]            out_data,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err_unexp,
  output logic                       err_ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_unexp_q, err_unexp_d;
  logic            err_ovf_q, err_ovf_d;
  logic [FLEN-1:0] mem_q [DEPTH];

  logic [CW:0] credits_used;
  logic        issue;
  logic        accept;
  logic        pop;
  logic        full;
  logic        none_inflight;

  always_comb begin
    // Credit decision uses registered state only, never a same-cycle pop.
    credits_used  = {1'b0, inflight_q} + {1'b0, count_q};
    src_rdy       = !rst && (credits_used < (CW + 1)'(DEPTH));
    issue         = src_vld && src_rdy;
    arg_vld       = issue;

    full          = (count_q == CW'(DEPTH));
    none_inflight = (inflight_q == '0);
    accept        = res_vld && !none_inflight && !full;

    out_vld       = (count_q != '0);
    pop           = out_vld && out_rdy;
    out_data      = out_vld ? mem_q[rd_ptr_q] : '0;

    inflight      = inflight_q;
    count         = count_q;
    err_unexp     = err_unexp_q;
    err_ovf       = err_ovf_q;
  end

  always_comb begin
    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    wr_ptr_d    = wr_ptr_q + PW'(accept);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    inflight_d  = inflight_q + CW'(issue) - CW'(accept);
    count_d     = count_q + CW'(accept) - CW'(pop);
    err_unexp_d = err_unexp_q || (res_vld && none_inflight);
    err_ovf_d   = err_ovf_q || (res_vld && full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      err_unexp_q <= err_unexp_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Storage is intentionally not reset; out_data is masked by out_vld.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= res;
    end
  end

endmodule

// File: tb/tb_fp_pipe_result_buffer.sv
module tb_fp_pipe_result_buffer;

  localparam int unsigned FLEN  = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned LAT   = 13;
  localparam logic [63:0] BASE  = 64'h3FF0000000000000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            src_vld = 1'b0;
  logic            src_rdy;
  logic            arg_vld;
  logic            res_vld = 1'b0;
  logic [FLEN-1:0] res = '0;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [FLEN-1:0] out_data;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   count;
  logic            err_unexp;
  logic            err_ovf;

  always #5 clk = ~clk;

  fp_pipe_result_buffer #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_vld  (src_vld),
    .src_rdy  (src_rdy),
    .arg_vld  (arg_vld),
    .res_vld  (res_vld),
    .res      (res),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .inflight (inflight),
    .count    (count),
    .err_unexp(err_unexp),
    .err_ovf  (err_ovf)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_infl, m_cnt;
  bit          m_eu, m_eo;
  int          n_issue = 0;
  int          n_pop = 0;
  int          rdy_low = 0;
  int          tok = 0;
  logic [63:0] sb[$];
  logic        pipe_v[LAT];
  logic [63:0] pipe_d[LAT];
  logic        inj_vld = 1'b0;
  logic [63:0] inj_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_infl = 0;
    m_cnt  = 0;
    m_eu   = 1'b0;
    m_eo   = 1'b0;
    sb.delete();
    for (int i = 0; i < int'(LAT); i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
  endtask

  // One clock cycle: drive the pipeline result, check at negedge against the
  // model, update the model and scoreboard, then advance past the posedge.
  task automatic tick();
    logic [63:0] d;
    bit m_rdy, m_iss, m_acc, m_pop;
    res_vld = pipe_v[LAT-1] | inj_vld;
    res     = inj_vld ? inj_data : pipe_d[LAT-1];
    @(negedge clk);
    m_rdy = (m_infl + m_cnt) < int'(DEPTH);
    m_iss = src_vld && m_rdy;
    m_acc = res_vld && (m_infl != 0) && (m_cnt != int'(DEPTH));
    m_pop = (m_cnt != 0) && out_rdy;
    if (!src_rdy) rdy_low++;
    chk("src_rdy",   64'(src_rdy),   64'(m_rdy));
    chk("arg_vld",   64'(arg_vld),   64'(m_iss));
    chk("out_vld",   64'(out_vld),   64'(m_cnt != 0));
    chk("inflight",  64'(inflight),  64'(m_infl));
    chk("count",     64'(count),     64'(m_cnt));
    chk("err_unexp", 64'(err_unexp), 64'(m_eu));
    chk("err_ovf",   64'(err_ovf),   64'(m_eo));
    if (m_cnt == 0) chk("out_data_idle", out_data, 64'h0);
    if (m_pop) begin
      d = (sb.size() != 0) ? sb.pop_front() : 64'hx;
      chk("out_data", out_data, d);
      n_pop++;
    end
    if (res_vld && m_infl == 0) m_eu = 1'b1;
    if (res_vld && m_cnt == int'(DEPTH)) m_eo = 1'b1;
    d = BASE + 64'(tok);
    if (m_iss) begin
      sb.push_back(d);
      tok++;
      n_issue++;
    end
    m_infl = m_infl + int'(m_iss) - int'(m_acc);
    m_cnt  = m_cnt + int'(m_acc) - int'(m_pop);
    for (int i = int'(LAT) - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = m_iss;
    pipe_d[0] = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    src_vld = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 200 && (m_infl != 0 || m_cnt != 0); k++) tick();
    out_rdy = 1'b0;
    chk("drain_count",    64'(count),    64'd0);
    chk("drain_inflight", 64'(inflight), 64'd0);
  endtask

  task automatic wait_arrival();
    for (int k = 0; k < 40 && !pipe_v[LAT-1]; k++) tick();
  endtask

  int base;

  initial begin
    model_reset();
    // Reset state; src_vld held high to show no issue under reset.
    src_vld = 1'b1;
    #3;
    chk("rst_src_rdy",   64'(src_rdy),   64'd0);
    chk("rst_arg_vld",   64'(arg_vld),   64'd0);
    chk("rst_out_vld",   64'(out_vld),   64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_inflight",  64'(inflight),  64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_err_unexp", 64'(err_unexp), 64'd0);
    chk("rst_err_ovf",   64'(err_ovf),   64'd0);
    src_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post_rst_src_rdy", 64'(src_rdy), 64'd1);

    // Back-to-back stream with consumer always ready.
    src_vld = 1'b1;
    out_rdy = 1'b1;
    rdy_low = 0;
    for (int i = 0; i < 100; i++) tick();
    src_vld = 1'b0;
    chk("stream_issues",  64'(n_issue), 64'd100);
    chk("stream_rdy_low", 64'(rdy_low), 64'd0);
    drain();
    chk("stream_pops", 64'(n_pop), 64'd100);

    // Consumer stall: credits run out at DEPTH.
    base    = n_issue;
    out_rdy = 1'b0;
    src_vld = 1'b1;
    repeat (40) tick();
    chk("stall_issues",   64'(n_issue - base), 64'd16);
    chk("stall_count",    64'(count),          64'd16);
    chk("stall_inflight", 64'(inflight),       64'd0);
    chk("stall_src_rdy",  64'(src_rdy),        64'd0);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("stall_pop_count",  64'(count),   64'd15);
    chk("credit_return",    64'(src_rdy), 64'd1);
    tick();
    chk("stall_one_more",   64'(n_issue - base), 64'd17);
    repeat (20) tick();
    chk("stall_no_more",    64'(n_issue - base), 64'd17);
    drain();

    // Accept and pop in the same cycle at count = 5.
    src_vld = 1'b1;
    repeat (5) tick();
    src_vld = 1'b0;
    repeat (LAT + 1) tick();
    chk("simul_pre_count", 64'(count), 64'd5);
    src_vld = 1'b1;
    tick();
    src_vld = 1'b0;
    wait_arrival();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("simul_count", 64'(count), 64'd5);
    drain();

    // Issue and accept in the same cycle at inflight = 3.
    src_vld = 1'b1;
    tick();
    src_vld = 1'b0;
    repeat (2) tick();
    src_vld = 1'b1;
    repeat (2) tick();
    src_vld = 1'b0;
    wait_arrival();
    chk("simul_pre_inflight", 64'(inflight), 64'd3);
    src_vld = 1'b1;
    tick();
    src_vld = 1'b0;
    chk("simul_inflight", 64'(inflight), 64'd3);
    drain();

    // Pointer wrap with random consumer readiness.
    tok     = 0;
    base    = n_issue;
    src_vld = 1'b1;
    for (int k = 0; k < 400 && (n_issue - base) < 40; k++) begin
      out_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    src_vld = 1'b0;
    chk("wrap_issues", 64'(n_issue - base), 64'd40);
    drain();

    // Unexpected result with nothing in flight.
    inj_vld  = 1'b1;
    inj_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    inj_vld = 1'b0;
    chk("unexp_flag",  64'(err_unexp), 64'd1);
    chk("unexp_count", 64'(count),     64'd0);
    repeat (5) tick();
    chk("unexp_sticky", 64'(err_unexp), 64'd1);

    // Mid-operation asynchronous reset at count = 7, inflight = 4.
    out_rdy = 1'b0;
    src_vld = 1'b1;
    repeat (7) tick();
    src_vld = 1'b0;
    for (int k = 0; k < 40 && m_cnt != 7; k++) tick();
    src_vld = 1'b1;
    repeat (4) tick();
    src_vld = 1'b0;
    chk("mid_count",    64'(count),    64'd7);
    chk("mid_inflight", 64'(inflight), 64'd4);
    #2 rst = 1'b1;
    res_vld = 1'b0;
    #1;
    chk("arst_src_rdy",   64'(src_rdy),   64'd0);
    chk("arst_out_vld",   64'(out_vld),   64'd0);
    chk("arst_out_data",  out_data,       64'd0);
    chk("arst_inflight",  64'(inflight),  64'd0);
    chk("arst_count",     64'(count),     64'd0);
    chk("arst_err_unexp", 64'(err_unexp), 64'd0);
    chk("arst_err_ovf",   64'(err_ovf),   64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_rel_src_rdy", 64'(src_rdy), 64'd1);
    chk("arst_rel_out_vld", 64'(out_vld), 64'd0);
    src_vld = 1'b1;
    out_rdy = 1'b1;
    repeat (5) tick();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
